// File: rtl/circ_pkg.sv
// Shared types and constants for the circularity scheduler.
package circ_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } circ_state_t;

  // 4*pi*100 with pi taken as 3, so the quotient is circularity x100
  localparam int PI4_SCALE = 1200;
  localparam int DIV_W     = 32;
  localparam int PERIM_SAT = 65535;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int   pos;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/circularity_scheduler.sv
// Shares one external divider between NUM_REQ blob-statistics requesters.
// Optional divider watchdog enabled by defining CIRC_TIMEOUT_EN.
module circularity_scheduler
  import circ_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 180,
  parameter int HEIGHT         = 320,
  parameter int AW             = $clog2(WIDTH*HEIGHT) + 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic [NUM_REQ*AW-1:0]      area_in,
  input  logic [NUM_REQ*AW-1:0]      perimeter_in,
  output logic [NUM_REQ-1:0]         grant_out,
  output logic                       busy_out,
  output logic                       result_valid_out,
  output logic [$clog2(NUM_REQ)-1:0] result_id_out,
  output logic [AW-1:0]              result_out,
  output logic                       result_err_out,
  output logic [31:0]                div_dividend_out,
  output logic [31:0]                div_divisor_out,
  output logic                       div_valid_out,
  input  logic [31:0]                div_quotient_in,
  input  logic                       div_valid_in,
  input  logic                       div_error_in,
  input  logic                       div_busy_in
);

  localparam int IDW = $clog2(NUM_REQ);

  function automatic logic [DIV_W-1:0] scale_area(input logic [AW-1:0] a);
    return DIV_W'(a) * DIV_W'(PI4_SCALE);
  endfunction

  function automatic logic [DIV_W-1:0] sat_divisor(input logic [AW-1:0] p);
    if (DIV_W'(p) > DIV_W'(PERIM_SAT)) return '1;
    return DIV_W'(p) * DIV_W'(p);
  endfunction

  function automatic logic [AW-1:0] sat_result(input logic [DIV_W-1:0] q);
    if ((q >> AW) != '0) return '1;
    return AW'(q);
  endfunction

  circ_state_t        state, next_state;
  logic [IDW-1:0]     ptr, arb_idx, id_p0;
  logic [NUM_REQ-1:0] arb_grant;
  logic [AW-1:0]      area_sel, perim_sel;
  logic               perim_zero_p0, start, timeout, finish_wait;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_in),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign area_sel    = area_in[int'(arb_idx)*AW +: AW];
  assign perim_sel   = perimeter_in[int'(arb_idx)*AW +: AW];
  assign start       = (state == IDLE) && (|req_in) && !div_busy_in;
  assign finish_wait = (state == WAIT) && (div_valid_in || timeout);

`ifdef CIRC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in)              wait_cnt <= '0;
    else if (state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = ISSUE;
      ISSUE:   next_state = perim_zero_p0 ? DONE : WAIT;
      WAIT:    if (div_valid_in || timeout) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture stage: operands latched on grant, held until the next grant
  always_ff @(posedge clk_in) begin
    if (start) begin
      id_p0         <= arb_idx;
      perim_zero_p0 <= (perim_sel == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      ptr              <= '0;
      grant_out        <= '0;
      busy_out         <= 1'b0;
      div_valid_out    <= 1'b0;
      div_dividend_out <= '0;
      div_divisor_out  <= '0;
      result_valid_out <= 1'b0;
      result_id_out    <= '0;
      result_out       <= '0;
      result_err_out   <= 1'b0;
    end else begin
      state            <= next_state;
      busy_out         <= (next_state != IDLE);
      grant_out        <= '0;
      div_valid_out    <= 1'b0;
      result_valid_out <= 1'b0;
      if (start) begin
        grant_out        <= arb_grant;
        ptr              <= (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        div_valid_out    <= (perim_sel != '0);
        div_dividend_out <= scale_area(area_sel);
        div_divisor_out  <= sat_divisor(perim_sel);
      end
      if (state == ISSUE && perim_zero_p0) begin
        result_valid_out <= 1'b1;
        result_id_out    <= id_p0;
        result_out       <= '0;
        result_err_out   <= 1'b1;
      end
      // A divider response in the same cycle as the watchdog takes priority
      if (finish_wait) begin
        result_valid_out <= 1'b1;
        result_id_out    <= id_p0;
        result_err_out   <= !div_valid_in || div_error_in;
        result_out       <= (div_valid_in && !div_error_in) ? sat_result(div_quotient_in) : '0;
      end
    end
  end

endmodule
